ibex_icache_scr_key_ctrl: RTL and testbench
===========================================

Name: ibex_icache_scr_key_ctrl

Overview:
Scramble-key manager for the ICache tag and data RAMs. It owns the key/nonce registers and the key-valid flag that feeds the scrambled RAM primitives. On an ICache invalidation it sequences a key request to the key source (OTP/keymgr), with timeout, bounded retry and a failure state. It sits between the core's icache_inval signal, the external key interface and the RAM key inputs.

Parameters:
KeyW, SCRAMBLE_KEY_W (128), key width.
NonceW, SCRAMBLE_NONCE_W (64), nonce width.
RndCnstKey, 128'hDDDDDDDDEEEEEEEEAAAAAAAADDDDDDDD, key reset value.
RndCnstNonce, 64'hBBBBEEEEEEEEFFFF, nonce reset value.
ReqTimeout, 1024, cycles to wait for an ack per attempt; 0 disables the timeout.
MaxRetries, 3, re-requests allowed after the first attempt times out.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
icache_inval_i  in  1  invalidation request from the core (level; sampled each cycle)
key_valid_i  in  1  key-source ack; key_i/nonce_i valid this cycle
key_i  in  KeyW  new key
nonce_i  in  NonceW  new nonce
key_req_o  out  1  key request to the key source
scr_key_o  out  KeyW  key to the RAMs (registered)
scr_nonce_o  out  NonceW  nonce to the RAMs (registered)
scr_key_valid_o  out  1  key valid to the RAMs and to the ICache
busy_o  out  1  controller not in IDLE
key_err_o  out  1  key fetch failed (level)

Behaviour:
- Reset values: scr_key_o=RndCnstKey, scr_nonce_o=RndCnstNonce, scr_key_valid_o=1, key_req_o=0, busy_o=0, key_err_o=0. State=IDLE, timer=0, retry_cnt=0. Reset mid-operation returns everything to these values immediately.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Counter widths: timer is $clog2(ReqTimeout+1). retry_cnt is $clog2(MaxRetries+1).
- State outputs:
  - IDLE: key_req_o=0, scr_key_valid_o=1.
  - REQ: key_req_o=1, scr_key_valid_o=0.
  - BACKOFF: key_req_o=0, scr_key_valid_o=0.
  - FAIL: key_req_o=0, scr_key_valid_o=0, key_err_o=1.
  - busy_o = (state != IDLE).
- IDLE:
  - icache_inval_i=1 -> REQ next cycle; timer=0, retry_cnt=0.
  - key_valid_i is ignored; key and nonce are never captured outside REQ.
- REQ:
  - Priority per cycle: ack > timeout.
  - key_valid_i=1 -> capture key_i/nonce_i into scr_key_o/scr_nonce_o, then IDLE next cycle. The new key and scr_key_valid_o=1 appear on the same edge.
  - Otherwise, with ReqTimeout!=0 and timer==ReqTimeout-1:
    - retry_cnt<MaxRetries -> BACKOFF, retry_cnt+1.
    - retry_cnt==MaxRetries -> FAIL.
  - Otherwise timer+1. The timer saturates (never wraps) when ReqTimeout=0.
  - icache_inval_i is ignored in REQ, because a fresh key is already pending. This includes the cycle in which the ack arrives: the ack wins and the controller goes to IDLE.
- BACKOFF: fixed 2 cycles with key_req_o=0, then REQ with timer=0.
- FAIL: held until icache_inval_i=1 -> REQ with retry_cnt=0 and timer=0. key_err_o clears on that same edge. key_valid_i is ignored in FAIL.
- key_req_o stays high continuously while in REQ. The key source must treat it as a level request, and one ack completes it.

Test Plan:
1. Reset, no stimulus -> scr_key_valid_o=1, scr_key_o=128'hDDDD_DDDD_EEEE_EEEE_AAAA_AAAA_DDDD_DDDD, scr_nonce_o=64'hBBBBEEEEEEEEFFFF, key_req_o=0, busy_o=0, key_err_o=0.
2. Normal fetch: icache_inval_i pulse in cycle 0; key_valid_i=1 with key_i=128'h1234...(any K) in cycle 4 -> cycles 1-4: key_req_o=1, scr_key_valid_o=0, busy_o=1; cycle 5: scr_key_valid_o=1, scr_key_o=K, key_req_o=0, busy_o=0.
3. Timeout and retry (ReqTimeout=8, MaxRetries=2): inval in cycle 0, no ack -> key_req_o high in cycles 1-8, low in 9-10, high from 11. An ack in cycle 8 of a repeat run is accepted, with no BACKOFF.
4. Failure (ReqTimeout=8, MaxRetries=2), no ack ever -> three 8-cycle request windows separated by 2-cycle gaps, then key_err_o=1 and busy_o=1 from cycle 29. A later icache_inval_i pulse -> key_err_o=0 and key_req_o=1 on the next cycle.
5. Unsolicited and simultaneous events:
   - key_valid_i=1 with a new key while in IDLE -> scr_key_o unchanged.
   - icache_inval_i and key_valid_i both high in the same REQ cycle -> key captured, IDLE next cycle, no new request issued.
6. rst_ni asserted asynchronously in the middle of REQ (cycle 3) -> key_req_o=0 and scr_key_valid_o=1 without waiting for a clock edge, and all reset values restored.

Source files
------------

// File: rtl/ibex_icache_scr_key_ctrl.sv
// Scramble-key manager for the ICache RAMs: holds key/nonce, and on invalidation
// fetches a fresh key from the key source with per-attempt timeout, bounded retry and a sticky failure state.
module ibex_icache_scr_key_ctrl #(
  parameter int unsigned KeyW         = 128,
  parameter int unsigned NonceW       = 64,
  parameter logic [KeyW-1:0]   RndCnstKey   = 128'hDDDDDDDDEEEEEEEEAAAAAAAADDDDDDDD,
  parameter logic [NonceW-1:0] RndCnstNonce = 64'hBBBBEEEEEEEEFFFF,
  parameter int unsigned ReqTimeout   = 1024,
  parameter int unsigned MaxRetries   = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              icache_inval_i,
  input  logic              key_valid_i,
  input  logic [KeyW-1:0]   key_i,
  input  logic [NonceW-1:0] nonce_i,
  output logic              key_req_o,
  output logic [KeyW-1:0]   scr_key_o,
  output logic [NonceW-1:0] scr_nonce_o,
  output logic              scr_key_valid_o,
  output logic              busy_o,
  output logic              key_err_o
);

  // Handshake: key_req_o is a level request held for the whole REQ state; a single
  // cycle with key_valid_i=1 (key_i/nonce_i valid in that cycle) completes it.

  localparam int unsigned TimerW = (ReqTimeout > 0) ? $clog2(ReqTimeout + 1) : 1;
  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam logic [TimerW-1:0] TimeoutLast = (ReqTimeout > 0) ? TimerW'(ReqTimeout - 1) : '0;
  localparam logic [TimerW-1:0] TimerSat    = '1;
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MaxRetries);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_FAIL    = 2'd3
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [TimerW-1:0]   r_timer, w_timer_nxt;
  logic [RetryW-1:0]   r_retry, w_retry_nxt;
  logic                r_backoff, w_backoff_nxt;
  logic                w_capture;
  logic                w_timeout;
  logic [KeyW-1:0]     r_key;
  logic [NonceW-1:0]   r_nonce;

  assign w_timeout = (ReqTimeout != 0) && (r_timer == TimeoutLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_retry   <= '0;
      r_backoff <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_retry   <= w_retry_nxt;
      r_backoff <= w_backoff_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_retry_nxt   = r_retry;
    w_backoff_nxt = r_backoff;
    w_capture     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (icache_inval_i) begin
          w_state_nxt = ST_REQ;
          w_timer_nxt = '0;
          w_retry_nxt = '0;
        end
      end
      ST_REQ: begin
        // Ack beats timeout; invalidations are ignored since a fresh key is already on its way.
        if (key_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          if (r_retry < RetryMax) begin
            w_state_nxt   = ST_BACKOFF;
            w_retry_nxt   = r_retry + RetryW'(1);
            w_backoff_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_FAIL;
          end
        end else if (r_timer != TimerSat) begin
          w_timer_nxt = r_timer + TimerW'(1);
        end
      end
      ST_BACKOFF: begin
        if (r_backoff) begin
          w_state_nxt   = ST_REQ;
          w_timer_nxt   = '0;
          w_backoff_nxt = 1'b0;
        end else begin
          w_backoff_nxt = 1'b1;
        end
      end
      ST_FAIL: begin
        if (icache_inval_i) begin
          w_state_nxt = ST_REQ;
          w_timer_nxt = '0;
          w_retry_nxt = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_key   <= RndCnstKey;
      r_nonce <= RndCnstNonce;
    end else if (w_capture) begin
      r_key   <= key_i;
      r_nonce <= nonce_i;
    end
  end

  assign scr_key_o       = r_key;
  assign scr_nonce_o     = r_nonce;
  assign key_req_o       = (r_state == ST_REQ);
  assign scr_key_valid_o = (r_state == ST_IDLE);
  assign busy_o          = (r_state != ST_IDLE);
  assign key_err_o       = (r_state == ST_FAIL);

endmodule

// File: tb/tb_ibex_icache_scr_key_ctrl.sv
// Directed bench for ibex_icache_scr_key_ctrl: one instance with a short timeout/retry
// budget and one with the timeout disabled.
module tb_ibex_icache_scr_key_ctrl;

  localparam logic [127:0] RST_KEY   = 128'hDDDD_DDDD_EEEE_EEEE_AAAA_AAAA_DDDD_DDDD;
  localparam logic [63:0]  RST_NONCE = 64'hBBBBEEEEEEEEFFFF;

  logic         clk;
  logic         rst_n;
  logic         inval, kv;
  logic [127:0] key;
  logic [63:0]  nonce;
  logic         req_o, valid_o, busy_o, err_o;
  logic [127:0] key_o;
  logic [63:0]  nonce_o;

  logic         z_inval, z_kv;
  logic [127:0] z_key;
  logic [63:0]  z_nonce;
  logic         z_req_o, z_valid_o, z_busy_o, z_err_o;
  logic [127:0] z_key_o;
  logic [63:0]  z_nonce_o;

  int n_tests = 0;
  int n_fail  = 0;

  ibex_icache_scr_key_ctrl #(.ReqTimeout(8), .MaxRetries(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .icache_inval_i(inval), .key_valid_i(kv),
    .key_i(key), .nonce_i(nonce), .key_req_o(req_o), .scr_key_o(key_o),
    .scr_nonce_o(nonce_o), .scr_key_valid_o(valid_o), .busy_o(busy_o), .key_err_o(err_o)
  );

  ibex_icache_scr_key_ctrl #(.ReqTimeout(0), .MaxRetries(3)) dut_nto (
    .clk_i(clk), .rst_ni(rst_n), .icache_inval_i(z_inval), .key_valid_i(z_kv),
    .key_i(z_key), .nonce_i(z_nonce), .key_req_o(z_req_o), .scr_key_o(z_key_o),
    .scr_nonce_o(z_nonce_o), .scr_key_valid_o(z_valid_o), .busy_o(z_busy_o), .key_err_o(z_err_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to the next cycle; inputs are driven and outputs sampled 1 time unit after posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic req, input logic vld,
                           input logic bsy, input logic err);
    chk({tag, ".req"},   req_o,   req);
    chk({tag, ".valid"}, valid_o, vld);
    chk({tag, ".busy"},  busy_o,  bsy);
    chk({tag, ".err"},   err_o,   err);
  endtask

  initial begin
    logic [127:0] k1, k2, k3, k4, k5, k6, k7, k8;
    logic exp_req;
    k1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    k2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    k3 = 128'hCAFE_F00D_DEAD_BEEF_0BAD_C0DE_1234_5678;
    k4 = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
    k5 = 128'h5A5A_5A5A_A5A5_A5A5_5A5A_5A5A_A5A5_A5A5;
    k6 = 128'h6666_6666_6666_6666_6666_6666_6666_6666;
    k7 = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
    k8 = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;

    rst_n = 1'b0; inval = 1'b0; kv = 1'b0; key = '0; nonce = '0;
    z_inval = 1'b0; z_kv = 1'b0; z_key = '0; z_nonce = '0;
    step(); step();
    chk("rst_in.key", key_o, RST_KEY);
    chk_state("rst_in", 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("rst.key", key_o, RST_KEY);
    chk("rst.nonce", {64'd0, nonce_o}, {64'd0, RST_NONCE});
    chk_state("rst", 1'b0, 1'b1, 1'b0, 1'b0);

    // normal fetch: ack in cycle 4
    inval = 1'b1; step(); inval = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk_state($sformatf("fetch.c%0d", c), 1'b1, 1'b0, 1'b1, 1'b0);
      if (c == 4) begin kv = 1'b1; key = k1; nonce = 64'h0102030405060708; end
      step();
    end
    kv = 1'b0;
    chk_state("fetch.c5", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fetch.key", key_o, k1);
    chk("fetch.nonce", {64'd0, nonce_o}, {64'd0, 64'h0102030405060708});

    // timeout and retry: windows 1-8, gap 9-10, request again from 11
    inval = 1'b1; step(); inval = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      exp_req = (c <= 8) || (c >= 11);
      chk($sformatf("retry.c%0d.req", c), req_o, exp_req);
      chk($sformatf("retry.c%0d.busy", c), busy_o, 1'b1);
      step();
    end
    kv = 1'b1; key = k2; step(); kv = 1'b0;
    chk_state("retry.ack", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("retry.key", key_o, k2);

    // ack on the last cycle of the window wins over the timeout
    inval = 1'b1; step(); inval = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("edge.c%0d.req", c), req_o, 1'b1);
      if (c == 8) begin kv = 1'b1; key = k3; end
      step();
    end
    kv = 1'b0;
    chk_state("edge.c9", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("edge.key", key_o, k3);

    // failure: three windows, then FAIL from cycle 29
    inval = 1'b1; step(); inval = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      exp_req = (c <= 8) || (c >= 11 && c <= 18) || (c >= 21 && c <= 28);
      chk($sformatf("fail.c%0d.req", c), req_o, exp_req);
      chk($sformatf("fail.c%0d.err", c), err_o, (c >= 29));
      chk($sformatf("fail.c%0d.busy", c), busy_o, 1'b1);
      step();
    end
    kv = 1'b1; key = k4; step(); kv = 1'b0;
    chk("fail.ack_ignored.key", key_o, k3);
    chk_state("fail.hold", 1'b0, 1'b0, 1'b1, 1'b1);
    inval = 1'b1; step(); inval = 1'b0;
    chk_state("fail.recover", 1'b1, 1'b0, 1'b1, 1'b0);
    kv = 1'b1; key = k5; step(); kv = 1'b0;
    chk("fail.recover.key", key_o, k5);
    chk_state("fail.recover.idle", 1'b0, 1'b1, 1'b0, 1'b0);

    // unsolicited ack in IDLE is ignored
    kv = 1'b1; key = k6; step(); kv = 1'b0;
    chk("unsol.key", key_o, k5);
    chk_state("unsol", 1'b0, 1'b1, 1'b0, 1'b0);

    // inval together with ack in REQ: ack wins, no new request
    inval = 1'b1; step(); inval = 1'b0; step();
    inval = 1'b1; kv = 1'b1; key = k7; step(); inval = 1'b0; kv = 1'b0;
    chk("simul.key", key_o, k7);
    chk_state("simul.c0", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_state("simul.c1", 1'b0, 1'b1, 1'b0, 1'b0);

    // asynchronous reset in the middle of REQ, checked before any clock edge
    inval = 1'b1; step(); inval = 1'b0; step(); step();
    chk("arst.pre.req", req_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_state("arst", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("arst.key", key_o, RST_KEY);
    chk("arst.nonce", {64'd0, nonce_o}, {64'd0, RST_NONCE});
    step();
    rst_n = 1'b1;
    step();
    chk_state("arst.after", 1'b0, 1'b1, 1'b0, 1'b0);

    // timeout disabled: request holds indefinitely until acked
    z_inval = 1'b1; step(); z_inval = 1'b0;
    repeat (60) step();
    chk("nto.req", z_req_o, 1'b1);
    chk("nto.err", z_err_o, 1'b0);
    chk("nto.valid", z_valid_o, 1'b0);
    z_kv = 1'b1; z_key = k8; step(); z_kv = 1'b0;
    chk("nto.key", z_key_o, k8);
    chk("nto.valid_after", z_valid_o, 1'b1);
    chk("nto.busy_after", z_busy_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
